// File: rtl/add_pipe.sv
// add_pipe: pipelined two-operand adder/subtractor.
//
// Operands are split into STAGES chunks of CW = WIDTH/STAGES bits. Each
// pipeline stage resolves one chunk with a ripple-carry add, so a result
// leaves every clock at full throughput. One global advance signal moves the
// whole pipe at once, with valid/ready flow control at both ends.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand beat present
//   in_ready   block accepts a beat this cycle
//   a, b       operands (WIDTH bits)
//   cin        carry-in, used only when op = 0
//   op         0 = a+b+cin, 1 = a-b (computed as a+~b+1)
//   out_valid  result present
//   out_ready  consumer accepts the result
//   sum        result bits [WIDTH-1:0]
//   cout       carry out of the MSB (subtract: 1 = no borrow)
//   ovf        two's-complement overflow
module add_pipe #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CW   = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;
   // Operand carry registers exist only between stages; the last stage
   // consumes its operands combinationally.
   localparam int OPS  = (STAGES > 1) ? STAGES - 1 : 1;

   // Per-stage registered state
   logic [STAGES-1:0]            vld_pipe;
   logic [STAGES-1:0][WIDTH-1:0] s_r;      // accumulated low sum bits
   logic [STAGES-1:0]            c_r;      // carry out of the chunk just resolved
   logic [OPS-1:0][WIDTH-1:0]    a_r;      // operand a carried down
   logic [OPS-1:0][WIDTH-1:0]    b_r;      // effective operand b carried down
   logic                         ovf_r;

   // Per-stage inputs (from predecessor) and next values
   logic [STAGES-1:0][WIDTH-1:0] pa, pb, ps, ns;
   logic [STAGES-1:0]            pc, pv, nc;
   logic [CW:0]                  chunk;
   logic                         nxt_ovf;
   logic                         adv;

   assign adv       = !vld_pipe[LAST] || out_ready;
   assign in_ready  = adv && !rst;
   assign out_valid = vld_pipe[LAST];
   assign sum       = s_r[LAST];
   assign cout      = c_r[LAST];
   assign ovf       = ovf_r;

   always_comb begin
      pa      = '0;
      pb      = '0;
      ps      = '0;
      pc      = '0;
      pv      = '0;
      ns      = '0;
      nc      = '0;
      chunk   = '0;
      nxt_ovf = 1'b0;

      // Stage 0 sees the raw operands; subtract folds into ~b with carry-in 1.
      pa[0] = a;
      pb[0] = op ? ~b : b;
      pc[0] = op | cin;
      pv[0] = in_valid && in_ready;

      for (int s = 1; s < STAGES; s++) begin
         pa[s] = a_r[s-1];
         pb[s] = b_r[s-1];
         ps[s] = s_r[s-1];
         pc[s] = c_r[s-1];
         pv[s] = vld_pipe[s-1];
      end

      for (int s = 0; s < STAGES; s++) begin
         chunk = {1'b0, pa[s][s*CW +: CW]} + {1'b0, pb[s][s*CW +: CW]}
               + {{CW{1'b0}}, pc[s]};
         ns[s] = ps[s];
         ns[s][s*CW +: CW] = chunk[CW-1:0];
         nc[s] = chunk[CW];
      end

      // Same-sign operands producing a different-sign result.
      nxt_ovf = (pa[LAST][WIDTH-1] == pb[LAST][WIDTH-1]) &&
                (ns[LAST][WIDTH-1] != pa[LAST][WIDTH-1]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
         s_r      <= '0;
         c_r      <= '0;
         a_r      <= '0;
         b_r      <= '0;
         ovf_r    <= 1'b0;
      end else if (adv) begin
         vld_pipe <= pv;
         // Data only loads behind a valid beat, so bubbles never disturb
         // the held result on the outputs.
         for (int s = 0; s < STAGES; s++) begin
            if (pv[s]) begin
               s_r[s] <= ns[s];
               c_r[s] <= nc[s];
            end
         end
         for (int s = 0; s < STAGES - 1; s++) begin
            if (pv[s]) begin
               a_r[s] <= pa[s];
               b_r[s] <= pb[s];
            end
         end
         if (pv[LAST]) ovf_r <= nxt_ovf;
      end
   end

endmodule
